mem_wb_skid_reg: RTL and testbench
==================================

Name: mem_wb_skid_reg

Overview:
Parametrised MEM→WB pipeline boundary register: the next generation of the freeze-style stage register. It replaces the global freeze with a valid/ready handshake backed by a 2-entry skid buffer, so in_ready is a register output and no combinational stall path crosses the stage. Adds flush (bubble insertion), valid-qualified control, occupancy reporting and a forwarding tap. Sits between the memory stage and the write-back stage of the ARM pipeline.

Parameters:
DATA_W, 32, width of ALU result and memory read data
DEST_W, 4, register-file destination index width
CTRL_W, 2, control bundle width; bit0 = WB_EN, bit1 = MEM_R_EN; bits above are pass-through

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset, sampled on rising edge of clk
in_valid  in  1  upstream presents a MEM-stage result
in_ready  out  1  stage accepts this cycle; registered, equals ~skid_full
in_alu  in  DATA_W  ALU result
in_mem  in  DATA_W  memory read data
in_dest  in  DEST_W  destination register
in_ctrl  in  CTRL_W  control bundle
flush  in  1  discard all held entries and the entry offered this cycle
out_valid  out  1  WB-side entry valid
out_ready  in  1  WB side consumes; a core freeze maps to out_ready=0
out_alu  out  DATA_W  head ALU result
out_mem  out  DATA_W  head memory data
out_dest  out  DEST_W  head destination
out_ctrl  out  CTRL_W  head control, forced to 0 when out_valid=0
occupancy  out  2  entries held (0..2)
fwd_wb_en  out  1  head will write back: out_valid & out_ctrl[0]
fwd_dest  out  DEST_W  head destination for hazard/forwarding unit

Behaviour:
- Storage: main register (drives outputs) plus one skid register; each has a valid bit. FSM states: EMPTY (0 entries), ONE (main valid), TWO (main + skid valid).
- Reset (rst=1 at edge): both valid bits 0, all data/dest/ctrl registers 0, state EMPTY. Hence out_valid=0, out_ctrl=0, out_* data=0, occupancy=0, in_ready=1, fwd_wb_en=0. rst overrides flush and all handshakes.
- accept = in_valid & in_ready; consume = out_valid & out_ready.
- EMPTY: accept → ONE, data loads main. No accept → stay.
- ONE: accept & consume → ONE, main reloads with new data. Accept only → TWO, data loads skid. Consume only → EMPTY. Neither → hold.
- TWO (in_ready=0, so no accept): consume → ONE, skid moves to main, skid invalidated. No consume → hold.
- in_ready is registered: next value is 1 unless next state is TWO. It is never combinationally dependent on out_ready.
- Latency: accepted entry appears on out_* one cycle after acceptance when the stage was EMPTY or consuming in ONE. FIFO order is preserved.
- Flush (rst=0): next state EMPTY, both valid bits 0, in_ready=1 next cycle. The entry offered in the flush cycle is dropped even if in_ready=1. Data registers may hold stale values, but out_ctrl is masked to 0. A consume in the flush cycle still counts for the downstream side.
- out_ctrl masking: out_ctrl = main_valid ? main_ctrl : 0, so WB_EN/MEM_R_EN never assert for a bubble.
- occupancy = main_valid + skid_valid. The encoding 2'b11 is unreachable and is asserted in simulation.
- Invariant: skid_valid implies main_valid.
- No throughput loss: sustained accept and consume every cycle stays in ONE at 1 entry/cycle.

Decomposition:
- Shared package pipe_pkg holds CTRL_WB_EN_BIT=0, CTRL_MEM_R_EN_BIT=1 and the state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
- One natural sub-module: pipe_payload_reg, a parametrised width-W enable register with sync reset, instantiated for main and skid on the concatenated {ctrl, dest, alu, mem} payload. FSM and muxing stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, out_ctrl=0, occupancy=0, in_ready=1 after release.
- Streaming: out_ready=1; push alu=0x11..0x14, dest=1..4, ctrl=2'b01 on consecutive cycles → each appears 1 cycle later in order; occupancy stays 1; in_ready stays 1.
- Stall fill: ONE with alu=0xA, out_ready=0, push alu=0xB → occupancy=2, in_ready=0 next cycle. Hold 3 cycles, outputs stable at 0xA. Raise out_ready → 0xA, then 0xB, then out_valid=0.
- Flush in TWO: entries 0xA/0xB held, flush=1 with in_valid=1, alu=0xC → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. 0xC never appears.
- Forwarding tap: head dest=7, ctrl=2'b11 → fwd_wb_en=1, fwd_dest=7. Same with ctrl=2'b10 → fwd_wb_en=0. EMPTY → fwd_wb_en=0.
- Reset mid-operation: TWO state, assert rst and flush together for 1 cycle → all outputs at reset values. No stale entry emerges afterwards.

Source files
------------

// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared definitions for the MEM->WB stage boundary: control-bundle bit
// positions and the skid-buffer FSM state encoding.
package pipe_pkg;

    localparam int CTRL_WB_EN_BIT    = 0;
    localparam int CTRL_MEM_R_EN_BIT = 1;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } skid_state_t;

endpackage

// File: rtl/mem_wb_skid_reg_payload.sv
// Width-W enable register with synchronous active-high reset; holds one
// {ctrl, dest, alu, mem} payload slot of the skid buffer.
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with valid/ready handshake and a 2-entry skid
// buffer; in_ready is registered so no stall path crosses the stage.
module mem_wb_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CTRL_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_mem,
    output logic [DEST_W-1:0] out_dest,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic              fwd_wb_en,
    output logic [DEST_W-1:0] fwd_dest
);

    localparam int PW = CTRL_W + DEST_W + 2 * DATA_W;

    skid_state_t   state;
    logic          main_valid;
    logic          skid_valid;
    logic          accept;
    logic          consume;
    logic          main_en;
    logic          skid_en;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic [CTRL_W-1:0] main_ctrl;

    // The entry offered during a flush is dropped even when in_ready is high.
    assign accept  = in_valid & in_ready & ~flush;
    assign consume = main_valid & out_ready;

    assign in_payload = {in_ctrl, in_dest, in_alu, in_mem};
    assign main_d     = (state == S_TWO) ? skid_q : in_payload;
    assign main_en    = ((state == S_EMPTY) & accept)
                      | ((state == S_ONE) & accept & consume)
                      | ((state == S_TWO) & consume);
    assign skid_en    = (state == S_ONE) & accept & ~consume;

    pipe_payload_reg #(.W(PW)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_payload_reg #(.W(PW)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_payload),
        .q   (skid_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (flush) begin
            state      <= S_EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        state      <= S_ONE;
                        main_valid <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && !consume) begin
                        state      <= S_TWO;
                        skid_valid <= 1'b1;
                        in_ready   <= 1'b0;
                    end else if (!accept && consume) begin
                        state      <= S_EMPTY;
                        main_valid <= 1'b0;
                    end
                end
                S_TWO: begin
                    if (consume) begin
                        state      <= S_ONE;
                        skid_valid <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_EMPTY;
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    in_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign {main_ctrl, out_dest, out_alu, out_mem} = main_q;

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
    assign fwd_wb_en = main_valid & main_ctrl[CTRL_WB_EN_BIT];
    assign fwd_dest  = out_dest;

    a_skid_implies_main: assert property (@(posedge clk) disable iff (rst)
        skid_valid |-> main_valid);
    a_occ_legal: assert property (@(posedge clk) disable iff (rst)
        occupancy != 2'b11);

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Self-checking bench for mem_wb_skid_reg: directed scenarios followed by
// random traffic, compared against a queue-based FIFO reference model.
module tb_mem_wb_skid_reg;

    localparam int DATA_W = 32;
    localparam int DEST_W = 4;
    localparam int CTRL_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_mem;
    logic [DEST_W-1:0] in_dest;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_mem;
    logic [DEST_W-1:0] out_dest;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic              fwd_wb_en;
    logic [DEST_W-1:0] fwd_dest;

    mem_wb_skid_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_alu    (in_alu),
        .in_mem    (in_mem),
        .in_dest   (in_dest),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_alu   (out_alu),
        .out_mem   (out_mem),
        .out_dest  (out_dest),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy),
        .fwd_wb_en (fwd_wb_en),
        .fwd_dest  (fwd_dest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
        logic [DEST_W-1:0] dest;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t q[$];
    logic   m_ready;
    int     n_asrt = 0;
    int     n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a FIFO of capacity 2; ready reflects free space after the edge.
    task automatic model_update(input logic v, input entry_t e, input logic fl,
                                input logic ordy, input logic r);
        logic acc;
        logic cons;
        if (r) begin
            q.delete();
        end else begin
            cons = (q.size() > 0) && ordy;
            acc  = v && m_ready && !fl;
            if (fl) begin
                q.delete();
            end else begin
                if (cons) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
        end
        m_ready = (q.size() < 2);
    endtask

    task automatic check_all();
        logic vld;
        vld = (q.size() > 0);
        chk("out_valid", {63'd0, out_valid}, {63'd0, vld});
        chk("occupancy", {62'd0, occupancy}, 64'(q.size()));
        chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
        if (vld) begin
            chk("out_alu", {32'd0, out_alu}, {32'd0, q[0].alu});
            chk("out_mem", {32'd0, out_mem}, {32'd0, q[0].mem});
            chk("out_dest", {60'd0, out_dest}, {60'd0, q[0].dest});
            chk("out_ctrl", {62'd0, out_ctrl}, {62'd0, q[0].ctrl});
            chk("fwd_wb_en", {63'd0, fwd_wb_en}, {63'd0, q[0].ctrl[0]});
            chk("fwd_dest", {60'd0, fwd_dest}, {60'd0, q[0].dest});
        end else begin
            chk("out_ctrl_bubble", {62'd0, out_ctrl}, 64'd0);
            chk("fwd_wb_en_bubble", {63'd0, fwd_wb_en}, 64'd0);
        end
    endtask

    task automatic step(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] m,
                        input logic [DEST_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic fl, input logic ordy, input logic r);
        entry_t e;
        e.alu = a; e.mem = m; e.dest = d; e.ctrl = c;
        in_valid  = v;
        in_alu    = a;
        in_mem    = m;
        in_dest   = d;
        in_ctrl   = c;
        flush     = fl;
        out_ready = ordy;
        rst       = r;
        @(posedge clk);
        model_update(v, e, fl, ordy, r);
        #1;
        check_all();
    endtask

    initial begin
        m_ready = 1'b1;
        rst = 1'b1; in_valid = 1'b1; in_alu = 32'h55; in_mem = 32'h66;
        in_dest = 4'd9; in_ctrl = 2'b11; flush = 1'b0; out_ready = 1'b0;
        #1;

        // Reset held two cycles with a valid input offered.
        step(1, 32'h55, 32'h66, 4'd9, 2'b11, 0, 0, 1);
        step(1, 32'h55, 32'h66, 4'd9, 2'b11, 0, 0, 1);
        chk("rst_out_alu", {32'd0, out_alu}, 64'd0);
        chk("rst_out_mem", {32'd0, out_mem}, 64'd0);
        chk("rst_out_dest", {60'd0, out_dest}, 64'd0);

        // Streaming: one entry per cycle, each visible one cycle later.
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h11 + 32'(i), 32'h100 + 32'(i), 4'(i + 1), 2'b01, 0, 1, 0);
            chk("stream_alu", {32'd0, out_alu}, {32'd0, 32'h11 + 32'(i)});
            chk("stream_occ", {62'd0, occupancy}, 64'd1);
        end
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("stream_drain", {63'd0, out_valid}, 64'd0);

        // Stall fill, hold, then drain in order.
        step(1, 32'hA, 32'h0, 4'd2, 2'b01, 0, 0, 0);
        step(1, 32'hB, 32'h0, 4'd3, 2'b01, 0, 0, 0);
        chk("fill_occ", {62'd0, occupancy}, 64'd2);
        chk("fill_ready", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'hEE, 32'h0, 4'd5, 2'b01, 0, 0, 0);
            chk("hold_alu", {32'd0, out_alu}, 64'hA);
        end
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("drain_b", {32'd0, out_alu}, 64'hB);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("drain_empty", {63'd0, out_valid}, 64'd0);

        // Flush while full; offered 0xC must be dropped.
        step(1, 32'hA, 32'h0, 4'd2, 2'b11, 0, 0, 0);
        step(1, 32'hB, 32'h0, 4'd3, 2'b11, 0, 0, 0);
        step(1, 32'hC, 32'h0, 4'd4, 2'b11, 1, 0, 0);
        chk("flush_occ", {62'd0, occupancy}, 64'd0);
        chk("flush_ctrl", {62'd0, out_ctrl}, 64'd0);
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("flush_no_c", {63'd0, out_valid}, 64'd0);

        // Forwarding tap.
        step(1, 32'h1, 32'h0, 4'd7, 2'b11, 0, 0, 0);
        chk("fwd_en_11", {63'd0, fwd_wb_en}, 64'd1);
        chk("fwd_dest_7", {60'd0, fwd_dest}, 64'd7);
        step(1, 32'h2, 32'h0, 4'd7, 2'b10, 0, 1, 0);
        chk("fwd_en_10", {63'd0, fwd_wb_en}, 64'd0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("fwd_en_empty", {63'd0, fwd_wb_en}, 64'd0);

        // Reset together with flush while full.
        step(1, 32'h31, 32'h0, 4'd1, 2'b01, 0, 0, 0);
        step(1, 32'h32, 32'h0, 4'd2, 2'b01, 0, 0, 0);
        step(1, 32'h33, 32'h0, 4'd3, 2'b01, 1, 0, 1);
        chk("midrst_alu", {32'd0, out_alu}, 64'd0);
        chk("midrst_dest", {60'd0, out_dest}, 64'd0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);

        // Random traffic against the FIFO model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7), $urandom, $urandom, 4'($urandom), 2'($urandom),
                 ($urandom_range(0, 99) < 5), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) < 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
